// File: rtl/nn_pkg.sv
// Shared neural-network datapath package.
// Contents:
//   NN_DW, NN_AW, NN_DIMW : default data, address and dimension widths
//   ST_*                  : writeback FSM state encodings
//   saturate()            : clamps a DW+2 bit signed value to DW bits
package nn_pkg;

  localparam int NN_DW   = 32;
  localparam int NN_AW   = 16;
  localparam int NN_DIMW = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // The value fits in DW bits exactly when its top three bits agree (the
  // DW-1 sign bit plus the two guard bits). Otherwise clamp toward the
  // sign carried in the MSB.
  function automatic logic [NN_DW-1:0] saturate(input logic signed [NN_DW+1:0] x);
    logic [NN_DW-1:0] res;
    if ((x[NN_DW+1:NN_DW-1] == 3'b000) || (x[NN_DW+1:NN_DW-1] == 3'b111)) begin
      res = x[NN_DW-1:0];
    end else if (x[NN_DW+1]) begin
      res = {1'b1, {(NN_DW-1){1'b0}}};
    end else begin
      res = {1'b0, {(NN_DW-1){1'b1}}};
    end
    return res;
  endfunction

endpackage

// File: rtl/bias_act_writeback_if.sv
// Bus bundle for bias_act_writeback.
// Members:
//   in_valid/in_addr/in_data  : result write stream from the matmul engine
//   bias_addr/bias_data       : bias memory read port (data one cycle after address)
//   out_we/out_addr/out_data  : activation memory write port
// Modports: slave = the writeback block, master = the surrounding system.
//
// Handshake: both streams are strobe-only, with no ready/backpressure.
// A beat transfers on every rising clock edge where the strobe (in_valid or
// out_we) is 1. The address and data signals are meaningful only on such
// an edge.
interface bias_act_writeback_if import nn_pkg::*; #(
  parameter int DW   = NN_DW,
  parameter int AW   = NN_AW,
  parameter int DIMW = NN_DIMW
);

  logic            in_valid;
  logic [AW-1:0]   in_addr;
  logic [DW-1:0]   in_data;
  logic [DIMW-1:0] bias_addr;
  logic [DW-1:0]   bias_data;
  logic [AW-1:0]   out_addr;
  logic [DW-1:0]   out_data;
  logic            out_we;

  modport slave (
    input  in_valid, in_addr, in_data, bias_data,
    output bias_addr, out_addr, out_data, out_we
  );

  modport master (
    output in_valid, in_addr, in_data, bias_data,
    input  bias_addr, out_addr, out_data, out_we
  );

endinterface

// File: rtl/act_requant.sv
// Combinational activation and requantisation.
// Ports:
//   i_sum     : DW+1 bit signed biased result
//   i_relu_en : clamp negative sums to zero
//   i_shift   : arithmetic right shift amount, rounding half up
//   o_act     : DW bit signed saturated activation
module act_requant import nn_pkg::*; #(
  parameter int DW = NN_DW
) (
  input  logic signed [DW:0]   i_sum,
  input  logic                 i_relu_en,
  input  logic [4:0]           i_shift,
  output logic [DW-1:0]        o_act
);

  localparam logic signed [DW+1:0] ONE = 1;

  logic signed [DW+1:0] w_relu;
  logic signed [DW+1:0] w_round;
  logic signed [DW+1:0] w_shifted;

  assign w_relu    = (i_relu_en && i_sum[DW]) ? '0 : {i_sum[DW], i_sum};
  // Adding half an LSB before the floor shift gives round-half-up.
  assign w_round   = (i_shift == 5'd0) ? '0 : (ONE << (i_shift - 5'd1));
  assign w_shifted = (w_relu + w_round) >>> i_shift;
  assign o_act     = saturate(w_shifted);

endmodule

// File: rtl/bias_act_writeback.sv
// Bias-add, activation and writeback stage behind the matmul engine.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : pulse that latches m, n, shift, relu_en and arms a run
//   m, n              : output rows and columns (both >= 1)
//   shift, relu_en    : requantisation shift and ReLU enable
//   bus (slave)       : result stream in, bias read port, activation write out
//   done              : level, high from drain completion until the next start
//   seq_err           : sticky, set when in_addr differs from the running count
//   o_dbg_state       : current FSM state, for observation
// Pipeline: S0 captures the element and issues the bias read. S1 adds the
// bias. S2 registers the requantised write. The latency is 3 cycles at one
// element per cycle.
module bias_act_writeback import nn_pkg::*; #(
  parameter int DW   = NN_DW,
  parameter int AW   = NN_AW,
  parameter int DIMW = NN_DIMW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [DIMW-1:0] m,
  input  logic [DIMW-1:0] n,
  input  logic [4:0]      shift,
  input  logic            relu_en,
  bias_act_writeback_if.slave bus,
  output logic            done,
  output logic            seq_err,
  output logic [1:0]      o_dbg_state
);

  localparam int CW = 2 * DIMW;
  localparam logic [DIMW-1:0] ONE_D = 1;
  localparam logic [CW-1:0]   ONE_C = 1;

  logic [1:0]          r_state;
  logic [DIMW-1:0]     r_n;
  logic [CW-1:0]       r_total;
  logic [4:0]          r_shift;
  logic                r_relu;
  logic [DIMW-1:0]     r_col;
  logic [CW-1:0]       r_count;
  logic                r_done;
  logic                r_seq_err;

  logic                r_s0_valid;
  logic [AW-1:0]       r_s0_addr;
  logic [DW-1:0]       r_s0_data;
  logic [DIMW-1:0]     r_bias_addr;
  logic                r_s1_valid;
  logic [AW-1:0]       r_s1_addr;
  logic signed [DW:0]  r_s1_sum;
  logic                r_out_we;
  logic [AW-1:0]       r_out_addr;
  logic [DW-1:0]       r_out_data;

  logic                w_acc;
  logic                w_last;
  logic                w_empty;
  logic signed [DW:0]  w_sum;
  logic [DW-1:0]       w_act;

  // Elements arriving outside RUN are dropped entirely.
  assign w_acc   = (r_state == ST_RUN) && bus.in_valid;
  assign w_last  = (r_count == (r_total - ONE_C));
  assign w_empty = !r_s0_valid && !r_s1_valid;
  // The bias word returned this cycle belongs to the element held in S0.
  assign w_sum   = $signed({r_s0_data[DW-1], r_s0_data})
                 + $signed({bus.bias_data[DW-1], bus.bias_data});

  act_requant #(.DW(DW)) u_requant (
    .i_sum     (r_s1_sum),
    .i_relu_en (r_relu),
    .i_shift   (r_shift),
    .o_act     (w_act)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_n       <= '0;
      r_total   <= '0;
      r_shift   <= '0;
      r_relu    <= 1'b0;
      r_col     <= '0;
      r_count   <= '0;
      r_done    <= 1'b0;
      r_seq_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state   <= ST_RUN;
            r_n       <= n;
            r_total   <= CW'(m) * CW'(n);
            r_shift   <= shift;
            r_relu    <= relu_en;
            r_col     <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_seq_err <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_acc) begin
            r_col   <= (r_col == (r_n - ONE_D)) ? '0 : r_col + ONE_D;
            r_count <= r_count + ONE_C;
            if (CW'(bus.in_addr) != r_count) r_seq_err <= 1'b1;
            if (w_last) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_empty) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0_valid  <= 1'b0;
      r_s0_addr   <= '0;
      r_s0_data   <= '0;
      r_bias_addr <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_addr   <= '0;
      r_s1_sum    <= '0;
      r_out_we    <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
    end else begin
      r_s0_valid <= w_acc;
      if (w_acc) begin
        r_s0_addr   <= bus.in_addr;
        r_s0_data   <= bus.in_data;
        r_bias_addr <= r_col;
      end
      r_s1_valid <= r_s0_valid;
      if (r_s0_valid) begin
        r_s1_addr <= r_s0_addr;
        r_s1_sum  <= w_sum;
      end
      r_out_we <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_addr <= r_s1_addr;
        r_out_data <= w_act;
      end
    end
  end

  assign bus.bias_addr = r_bias_addr;
  assign bus.out_addr  = r_out_addr;
  assign bus.out_data  = r_out_data;
  assign bus.out_we    = r_out_we;
  assign done          = r_done;
  assign seq_err       = r_seq_err;
  assign o_dbg_state   = r_state;

endmodule

// File: doc/bias_act_writeback.md
Name: bias_act_writeback

Overview:
Post-processing stage directly downstream of the matrix-multiply engine. It consumes the engine's result write stream (address, data, write strobe) and adds a per-column bias from a synchronous bias memory. It then applies optional ReLU, a rounding arithmetic right shift and signed saturation, and writes the result to the layer activation memory. It also tracks element count and column index, and raises done once all M*N results have drained.

Parameters:
DW, 32, data width of results, bias and output (signed)
AW, 16, result/activation address width
DIMW, 10, width of dimension inputs m, n

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches m, n, shift, relu_en and arms the block
m  in  DIMW  output rows (layer batch/rows), >=1
n  in  DIMW  output columns (neurons), >=1
shift  in  5  right-shift amount for requantisation, 0..31
relu_en  in  1  1 = clamp negatives to 0
in_valid  in  1  result strobe from matmul write_enable
in_addr  in  AW  result address, row-major i*n+j
in_data  in  DW  signed result value
bias_addr  out  DIMW  bias memory read address (column j)
bias_data  in  DW  signed bias, valid exactly 1 cycle after bias_addr is registered
out_addr  out  AW  activation memory write address
out_data  out  DW  signed activation value
out_we  out  1  activation write strobe
done  out  1  level; high from drain completion until next start
seq_err  out  1  sticky; in_addr did not equal expected running index

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; bias_addr=0, out_addr=0, out_data=0, out_we=0, done=0, seq_err=0; all counters, pipeline valids and config registers cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start. Latch config; clear col=0, count=0, done=0, seq_err=0.
  - RUN -> DRAIN when the accepted element has count == m*n-1.
  - DRAIN -> DONE when all pipeline valids are 0.
  - DONE -> RUN on start, with re-latch and clears as in IDLE. done stays 1 in DONE.
- start in RUN/DRAIN: ignored.
- in_valid outside RUN: ignored. No write is produced, and seq_err is not set.
- Pipeline, 3 stages, throughput 1 element/cycle, latency 3 cycles from in_valid to out_we:
  - S0 (edge where in_valid sampled): register addr, data and valid. Drive bias_addr<=col.
    - col increments, wrapping to 0 when col==n-1.
    - count increments.
    - If in_addr != count, set seq_err. The element is still processed.
  - S1: sum = sign-extended in_data + bias_data, computed at DW+1 bits.
  - S2: if relu_en and sum<0, sum=0. Then apply shift with round-half-up: (sum + (shift? 1<<(shift-1) : 0)) >>> shift, at DW+2 bits. Then saturate to [-2^(DW-1), 2^(DW-1)-1]. Register out_data and out_addr; out_we=1 for one cycle.
- n==1: col is always 0.
- shift==0: no rounding term.
- Saturation boundaries:
  - 0x7FFFFFFF + positive bias -> 0x7FFFFFFF.
  - 0x80000000 + negative bias -> 0x80000000, or 0 if relu_en.
- Back-to-back in_valid on consecutive cycles must be handled with no bubbles.
- Reset mid-operation: outputs return to reset values immediately. In-flight elements are discarded, and no write issues after rst_n deasserts.

Decomposition:
- Shared package (nn_pkg):
  - DW, AW and DIMW defaults.
  - FSM state encoding constants.
  - A saturate function (DW+2 -> DW) reused by later layers.
- One sub-module, act_requant: combinational ReLU, rounding shift and saturate.
- S2 registers, FSM, counters and bias fetch stay in the top module.

Test Plan:
- m=2, n=3, shift=0, relu_en=0, bias={10,-20,30}, results 0..5 at addr 0..5, one every 2 cycles.
  - Writes addr0..5 = {10,-19,32,13,-16,35}, each 3 cycles after its in_valid.
  - done rises after the last write. seq_err=0.
- Same, but relu_en=1 and data={-50,5,-100,0,0,0}, bias {10,-20,30}.
  - Outputs {0,0,0,10,0,30}.
- shift=4, relu_en=0, n=1, bias=0, data {23,24,-24,-25}.
  - Outputs {1,2,-1,-2} (round-half-up).
- n=1, bias=1, data 0x7FFFFFFF -> out 0x7FFFFFFF.
- n=1, bias=-1, data 0x80000000, relu_en=0 -> out 0x80000000.
- Six back-to-back in_valid cycles -> six consecutive out_we cycles.
- Addr sequence 0,1,3 -> seq_err=1 latched until next start; all three are still written.
- Assert rst_n=0 one cycle after an in_valid -> out_we stays 0 through and after reset; done=0.
- Then start a new m=1, n=1 run -> single correct write and done.
